// File: rtl/traffic_light_fsm.sv
// Two-road traffic light controller with a pedestrian walk phase.
// Time advances only on clk cycles with tick=1. Every output is a flop that
// changes on the same edge as the state register.
module traffic_light_fsm #(
  parameter int GREEN_MAIN = 10,
  parameter int GREEN_SIDE = 6,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 1,
  parameter int WALK_T     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state
);

  localparam logic [2:0] S_MAIN_GREEN  = 3'd0;
  localparam logic [2:0] S_MAIN_YELLOW = 3'd1;
  localparam logic [2:0] S_RED1        = 3'd2;
  localparam logic [2:0] S_SIDE_GREEN  = 3'd3;
  localparam logic [2:0] S_SIDE_YELLOW = 3'd4;
  localparam logic [2:0] S_RED2        = 3'd5;
  localparam logic [2:0] S_WALK        = 3'd6;

  // Lamp patterns, {R,Y,G}
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  // Last timer value of each state (duration - 1)
  localparam logic [7:0] LAST_GM = 8'(GREEN_MAIN - 1);
  localparam logic [7:0] LAST_GS = 8'(GREEN_SIDE - 1);
  localparam logic [7:0] LAST_Y  = 8'(YELLOW - 1);
  localparam logic [7:0] LAST_AR = 8'(ALL_RED - 1);
  localparam logic [7:0] LAST_W  = 8'(WALK_T - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       ped_q, ped_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;
  logic       walk_q, walk_d;
  logic [7:0] last;
  logic       expire;

  // Next state, timer and pedestrian latch
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ped_d   = ped_q;
    last    = 8'd0;
    case (state_q)
      S_MAIN_GREEN:                 last = LAST_GM;
      S_MAIN_YELLOW, S_SIDE_YELLOW: last = LAST_Y;
      S_RED1, S_RED2:               last = LAST_AR;
      S_SIDE_GREEN:                 last = LAST_GS;
      S_WALK:                       last = LAST_W;
      default:                      last = 8'd0;
    endcase
    expire = tick && (timer_q == last);

    if (tick) timer_d = timer_q + 8'd1;
    if (expire) begin
      timer_d = 8'd0;
      case (state_q)
        S_MAIN_GREEN: begin
          // Park at the last count so a later request leaves on its first tick
          if (side_req || ped_q) state_d = S_MAIN_YELLOW;
          else                   timer_d = timer_q;
        end
        S_MAIN_YELLOW: state_d = S_RED1;
        S_RED1:        state_d = ped_q ? S_WALK : S_SIDE_GREEN;
        S_SIDE_GREEN:  state_d = S_SIDE_YELLOW;
        S_SIDE_YELLOW: state_d = S_RED2;
        S_WALK:        state_d = S_RED2;
        S_RED2:        state_d = S_MAIN_GREEN;
        default:       state_d = S_RED2;
      endcase
    end
    // Unused code recovers to the all-red clearance without waiting for a tick
    if (state_q == 3'd7) begin
      state_d = S_RED2;
      timer_d = 8'd0;
    end

    // Button presses during WALK are dropped; the walk entry edge clears the
    // latch even when the button is held on that edge.
    if (ped_req && (state_q != S_WALK)) ped_d = 1'b1;
    if (expire && (state_q == S_RED1) && ped_q) ped_d = 1'b0;
  end

  // Lamp decode from the next state so lamps land on the same edge as state
  always_comb begin
    main_d = L_RED;
    side_d = L_RED;
    walk_d = 1'b0;
    case (state_d)
      S_MAIN_GREEN:  main_d = L_GRN;
      S_MAIN_YELLOW: main_d = L_YEL;
      S_SIDE_GREEN:  side_d = L_GRN;
      S_SIDE_YELLOW: side_d = L_YEL;
      S_WALK:        walk_d = 1'b1;
      default:       ;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RED2;
      timer_q <= 8'd0;
      ped_q   <= 1'b0;
      main_q  <= L_RED;
      side_q  <= L_RED;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ped_q   <= ped_d;
      main_q  <= main_d;
      side_q  <= side_d;
      walk_q  <= walk_d;
    end
  end

  assign state       = state_q;
  assign main_light  = main_q;
  assign side_light  = side_q;
  assign walk        = walk_q;
  assign ped_pending = ped_q;

endmodule
